list_sum_ctrl: RTL

LIST_SUM_CTRL -- requirements
Module: list_sum_ctrl

---
 rtl/list_sum_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/list_sum_ctrl.sv
// Control FSM for a linked-list summing datapath: walks head and next pointers,
// steers the sum/pointer registers and flags lists longer than MAX_NODES.
module list_sum_ctrl #(
  parameter int unsigned MAX_NODES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       next_zero,
  output logic       ld_sum,
  output logic       ld_next,
  output logic       sum_sel,
  output logic       next_sel,
  output logic       a_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] node_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HEAD,
    S_ADD,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] MaxCount = 8'(MAX_NODES);

  state_e     state_q, state_d;
  logic [7:0] count_d;
  logic       error_d;
  logic       abort_hit;

  assign abort_hit = abort && (state_q inside {S_CLEAR, S_HEAD, S_ADD, S_NEXT});

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_d = state_q;
    count_d = node_count;
    error_d = error;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          count_d = 8'd0;
          error_d = 1'b0;
        end
      end
      S_CLEAR: state_d = S_HEAD;
      S_HEAD:  state_d = next_zero ? S_DONE : S_ADD;
      S_ADD: begin
        count_d = (node_count == MaxCount) ? node_count : node_count + 8'd1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (next_zero) begin
          state_d = S_DONE;
        end else if (node_count == MaxCount) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort outranks every branch above, including the next_zero exit.
    if (abort_hit) begin
      state_d = S_IDLE;
      count_d = node_count;
      error_d = error;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      node_count <= 8'd0;
      error      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ld_sum     <= 1'b0;
      ld_next    <= 1'b0;
      sum_sel    <= 1'b0;
      next_sel   <= 1'b0;
      a_sel      <= 1'b0;
    end else begin
      // NOTE: outputs decode from state_d, so they are registered yet match state_q every cycle.
      state_q    <= state_d;
      node_count <= count_d;
      error      <= error_d;
      busy       <= state_d inside {S_CLEAR, S_HEAD, S_ADD, S_NEXT};
      done       <= (state_d == S_DONE);
      ld_sum     <= state_d inside {S_CLEAR, S_ADD};
      ld_next    <= state_d inside {S_CLEAR, S_HEAD, S_NEXT};
      sum_sel    <= (state_d == S_CLEAR);
      next_sel   <= (state_d == S_CLEAR);
      a_sel      <= state_d inside {S_HEAD, S_NEXT};
    end
  end

endmodule
